// File: rtl/uart_tx_serializer.sv
// Framed serial transmitter: start bit (0), DATA_W payload bits LSB first, stop bit (1).
// Every output comes from a register or from decoded state; tx_valid/tx_data only reach the next-state logic.
module uart_tx_serializer #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              tx_out,
   output logic              busy,
   output logic              frame_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              done_q, done_d;
   logic              bit_end;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      bit_end = (cnt_q == CNT_LAST);
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (tx_valid) begin
               shift_d = tx_data;
               cnt_d   = '0;
               idx_d   = '0;
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_d   = '0;
               tx_d    = shift_q[0];
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d   = '0;
               shift_d = shift_q >> 1;
               // Index saturates at the last bit so it never leaves 0..DATA_W-1.
               if (idx_q == IDX_LAST) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + 1'b1;
                  tx_d  = shift_d[0];
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_d   = '0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign tx_ready   = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign tx_out     = tx_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench: 8-bit/4-clock instance for framing, stability, back-to-back and reset;
// a 4-bit/1-clock instance for the single-cycle-bit corner.
module tb_uart_tx_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [7:0] d0;
   logic       v0, r0, o0, b0, f0;
   logic [3:0] d1;
   logic       v1, r1, o1, b1, f1;

   int n_chk = 0;
   int n_err = 0;

   uart_tx_serializer #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
      .clk(clk), .reset(reset), .tx_data(d0), .tx_valid(v0),
      .tx_ready(r0), .tx_out(o0), .busy(b0), .frame_done(f0)
   );

   uart_tx_serializer #(.DATA_W(4), .CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .reset(reset), .tx_data(d1), .tx_valid(v1),
      .tx_ready(r1), .tx_out(o1), .busy(b1), .frame_done(f1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_chk++;
      if (obs !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, want, $time);
      end
   endtask

   // Expected line level j cycles after the handshake edge.
   function automatic logic exp_bit(input int j, input int cpb, input int dw, input logic [7:0] d);
      int p;
      p = j / cpb;
      if (p == 0) return 1'b0;
      if (p <= dw) return d[p-1];
      return 1'b1;
   endfunction

   // Called at the negedge right after the handshake edge; returns at the done-pulse cycle.
   task automatic watch0(input logic [7:0] d, input string tag);
      for (int j = 0; j < 40; j++) begin
         chk({tag, "_tx"},   32'(o0), 32'(exp_bit(j, 4, 8, d)));
         chk({tag, "_busy"}, 32'(b0), 32'd1);
         chk({tag, "_rdy"},  32'(r0), 32'd0);
         chk({tag, "_done"}, 32'(f0), 32'd0);
         @(negedge clk);
      end
      chk({tag, "_end_done"}, 32'(f0), 32'd1);
      chk({tag, "_end_busy"}, 32'(b0), 32'd0);
      chk({tag, "_end_rdy"},  32'(r0), 32'd1);
      chk({tag, "_end_tx"},   32'(o0), 32'd1);
   endtask

   initial begin
      reset = 1'b1; v0 = 1'b0; d0 = '0; v1 = 1'b0; d1 = '0;
      #2;
      chk("rst_tx",   32'(o0), 32'd1);
      chk("rst_rdy",  32'(r0), 32'd1);
      chk("rst_busy", 32'(b0), 32'd0);
      chk("rst_done", 32'(f0), 32'd0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Single frame; tx_data changes right after the handshake and must not leak in.
      d0 = 8'hA5; v0 = 1'b1;
      @(negedge clk);
      v0 = 1'b0; d0 = 8'hFF;
      watch0(8'hA5, "single");
      @(negedge clk);
      chk("single_pulse_drop", 32'(f0), 32'd0);

      // Back-to-back with tx_valid held: one idle cycle, then the 0xFF frame.
      d0 = 8'h00; v0 = 1'b1;
      @(negedge clk);
      d0 = 8'hFF;
      watch0(8'h00, "b2b_a");
      @(negedge clk);
      v0 = 1'b0;
      watch0(8'hFF, "b2b_b");
      @(negedge clk);

      // Reset during data bit 3 of 0x5A.
      d0 = 8'h5A; v0 = 1'b1;
      @(negedge clk);
      v0 = 1'b0;
      repeat (17) @(negedge clk);
      chk("mid_busy_pre", 32'(b0), 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("mid_tx",   32'(o0), 32'd1);
      chk("mid_busy", 32'(b0), 32'd0);
      chk("mid_rdy",  32'(r0), 32'd1);
      chk("mid_done", 32'(f0), 32'd0);
      @(negedge clk);
      chk("mid_done_hold", 32'(f0), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      d0 = 8'h3C; v0 = 1'b1;
      @(negedge clk);
      v0 = 1'b0;
      watch0(8'h3C, "fresh");
      @(negedge clk);

      // Single-cycle bits: 0x9 -> 0,1,0,0,1,1 and done 6 cycles after the handshake.
      d1 = 4'h9; v1 = 1'b1;
      @(negedge clk);
      v1 = 1'b0;
      for (int j = 0; j < 6; j++) begin
         chk("c1_tx",   32'(o1), 32'(exp_bit(j, 1, 4, 8'h09)));
         chk("c1_busy", 32'(b1), 32'd1);
         chk("c1_done", 32'(f1), 32'd0);
         @(negedge clk);
      end
      chk("c1_end_done", 32'(f1), 32'd1);
      chk("c1_end_busy", 32'(b1), 32'd0);
      chk("c1_end_rdy",  32'(r1), 32'd1);
      chk("c1_end_tx",   32'(o1), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
